// File: rtl/ppu_bus_pkg.sv
// ppu_bus_pkg: shared types and constants for the PPU VRAM bus master.
package ppu_bus_pkg;
    typedef enum logic [2:0] {IDLE, ALE, HOLD, STROBE, RECOVER} state_t;
    localparam int AD_W        = 8;
    localparam int PA_W        = 14;
    localparam int ALE_CYC_MIN = 1;
    localparam int STB_CYC_MIN = 1;
endpackage

// File: rtl/ppu_bus_timer.sv
// ppu_bus_timer: loadable down-counter that stops at zero and flags it.
module ppu_bus_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/ppu_vram_bus_master.sv
// ppu_vram_bus_master: multiplexed VRAM bus initiator (ALE address phase, then /RD or /WR data phase).
module ppu_vram_bus_master
    import ppu_bus_pkg::*;
#(
    parameter int ALE_CYC = 1,
    parameter int STB_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [PA_W-1:0]   req_addr,
    input  logic [AD_W-1:0]   req_wdata,
    output logic              rd_valid,
    output logic [AD_W-1:0]   rd_data,
    output logic              ale,
    output logic [AD_W-1:0]   ad_out,
    output logic              ad_oe,
    input  logic [AD_W-1:0]   ad_in,
    output logic [PA_W-AD_W-1:0] pa_hi,
    output logic              n_rd,
    output logic              n_wr
);
    localparam int ALE_N = ALE_CYC < ALE_CYC_MIN ? ALE_CYC_MIN : ALE_CYC;
    localparam int STB_N = STB_CYC < STB_CYC_MIN ? STB_CYC_MIN : STB_CYC;
    localparam int T_MAX = ALE_N > STB_N ? ALE_N : STB_N;
    localparam int TW    = $clog2(T_MAX + 1);

    state_t              state, state_n;
    logic                acc, t_load, t_zero;
    logic [TW-1:0]       t_val;
    logic                we_q, we_n;
    logic [PA_W-1:0]     addr_q, addr_n;
    logic [AD_W-1:0]     wdata_q, wdata_n;
    logic                ale_n, oe_n, nrd_n, nwr_n, rdv_n;
    logic [AD_W-1:0]     out_n;
    logic [PA_W-AD_W-1:0] pa_n;

    assign req_ready = (state == IDLE || state == RECOVER) && !reset;
    assign acc       = req_valid && req_ready;

    ppu_bus_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_n = state;
        t_load  = 1'b0;
        t_val   = TW'(ALE_N - 1);
        case (state)
            IDLE:    if (acc) begin state_n = ALE; t_load = 1'b1; end
            ALE:     if (t_zero) state_n = HOLD;
            HOLD:    begin state_n = STROBE; t_load = 1'b1; t_val = TW'(STB_N - 1); end
            STROBE:  if (t_zero) state_n = RECOVER;
            RECOVER: begin state_n = acc ? ALE : IDLE; t_load = acc; end
            default: state_n = IDLE;
        endcase
        // Outputs are registered, so they are computed for the state being entered.
        we_n    = acc ? req_we : we_q;
        addr_n  = acc ? req_addr : addr_q;
        wdata_n = acc ? req_wdata : wdata_q;
        ale_n   = state_n == ALE;
        oe_n    = state_n == ALE ? 1'b1 : state_n == HOLD ? ad_oe : state_n == IDLE ? 1'b0 : we_n;
        out_n   = state_n == ALE ? addr_n[AD_W-1:0] :
                  ((state_n == STROBE || state_n == RECOVER) && we_n) ? wdata_n : ad_out;
        pa_n    = state_n == ALE ? addr_n[PA_W-1:AD_W] : pa_hi;
        nrd_n   = !(state_n == STROBE && !we_n);
        nwr_n   = !(state_n == STROBE && we_n);
        rdv_n   = state_n == RECOVER && !we_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ale      <= 1'b0;
            ad_oe    <= 1'b0;
            ad_out   <= '0;
            pa_hi    <= '0;
            n_rd     <= 1'b1;
            n_wr     <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            ale      <= ale_n;
            ad_oe    <= oe_n;
            ad_out   <= out_n;
            pa_hi    <= pa_n;
            n_rd     <= nrd_n;
            n_wr     <= nwr_n;
            rd_valid <= rdv_n;
            if (state == STROBE && t_zero && !we_q) rd_data <= ad_in;
        end
    end
endmodule

// File: tb/tb_ppu_vram_bus_master.sv
// tb_ppu_vram_bus_master: directed vectors for the VRAM bus master, default and stretched timing.
module tb_ppu_vram_bus_master;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b1, req_valid2 = 1'b0;
    logic       req_we = 1'b0;
    logic [13:0] req_addr = 14'h1111;
    logic [7:0] req_wdata = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic       req_ready, rd_valid, ale, ad_oe, n_rd, n_wr;
    logic [7:0] rd_data, ad_out;
    logic [5:0] pa_hi;
    logic       req_ready2, rd_valid2, ale2, ad_oe2, n_rd2, n_wr2;
    logic [7:0] rd_data2, ad_out2;
    logic [5:0] pa_hi2;
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    ppu_vram_bus_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .ale(ale), .ad_out(ad_out),
        .ad_oe(ad_oe), .ad_in(ad_in), .pa_hi(pa_hi), .n_rd(n_rd), .n_wr(n_wr)
    );

    ppu_vram_bus_master #(.ALE_CYC(2), .STB_CYC(3)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .ale(ale2), .ad_out(ad_out2),
        .ad_oe(ad_oe2), .ad_in(ad_in), .pa_hi(pa_hi2), .n_rd(n_rd2), .n_wr(n_wr2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bus protocol invariants, checked every cycle away from the active edge.
    always @(negedge clk) begin
        check("strobe_excl", 16'(n_rd | n_wr), 16'd1);
        check("ale_vs_strobe", 16'(ale & (~n_rd | ~n_wr)), 16'd0);
        check("strobe_excl2", 16'(n_rd2 | n_wr2), 16'd1);
    end

    initial begin
        repeat (3) tick;
        check("rst_ale", 16'(ale), 16'd0);
        check("rst_oe", 16'(ad_oe), 16'd0);
        check("rst_nrd", 16'(n_rd), 16'd1);
        check("rst_nwr", 16'(n_wr), 16'd1);
        check("rst_rdv", 16'(rd_valid), 16'd0);
        check("rst_ready", 16'(req_ready), 16'd0);
        check("rst_out", 16'(ad_out), 16'h00);
        check("rst_pa", 16'(pa_hi), 16'h00);
        check("rst_rdd", 16'(rd_data), 16'h00);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("post_rst_ready", 16'(req_ready), 16'd1);
        tick; tick;
        check("idle_ale", 16'(ale), 16'd0);
        check("idle_oe", 16'(ad_oe), 16'd0);

        // Read 0x2ABC
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h2ABC; ad_in = 8'h5A;
        tick;
        req_valid = 1'b0; req_addr = 14'h0000;
        check("rd_c1_ale", 16'(ale), 16'd1);
        check("rd_c1_out", 16'(ad_out), 16'hBC);
        check("rd_c1_pa", 16'(pa_hi), 16'h2A);
        check("rd_c1_oe", 16'(ad_oe), 16'd1);
        tick;
        check("rd_c2_ale", 16'(ale), 16'd0);
        check("rd_c2_out", 16'(ad_out), 16'hBC);
        check("rd_c2_oe", 16'(ad_oe), 16'd1);
        tick;
        check("rd_c3_nrd", 16'(n_rd), 16'd0);
        check("rd_c3_oe", 16'(ad_oe), 16'd0);
        tick;
        check("rd_c4_nrd", 16'(n_rd), 16'd0);
        check("rd_c4_rdv", 16'(rd_valid), 16'd0);
        tick;
        ad_in = 8'hFF;
        check("rd_c5_rdv", 16'(rd_valid), 16'd1);
        check("rd_c5_rdd", 16'(rd_data), 16'h5A);
        check("rd_c5_nrd", 16'(n_rd), 16'd1);
        tick;
        check("rd_c6_rdv", 16'(rd_valid), 16'd0);
        check("rd_c6_ready", 16'(req_ready), 16'd1);
        check("rd_c6_pa_hold", 16'(pa_hi), 16'h2A);

        // Write 0x3F00 <- 0x0F
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h3F00; req_wdata = 8'h0F;
        tick;
        req_valid = 1'b0; req_wdata = 8'h00;
        check("wr_c1_out", 16'(ad_out), 16'h00);
        check("wr_c1_pa", 16'(pa_hi), 16'h3F);
        tick;
        check("wr_c2_nwr", 16'(n_wr), 16'd1);
        tick;
        check("wr_c3_nwr", 16'(n_wr), 16'd0);
        check("wr_c3_out", 16'(ad_out), 16'h0F);
        check("wr_c3_oe", 16'(ad_oe), 16'd1);
        tick;
        check("wr_c4_nwr", 16'(n_wr), 16'd0);
        check("wr_c4_rdv", 16'(rd_valid), 16'd0);
        tick;
        check("wr_c5_nwr", 16'(n_wr), 16'd1);
        check("wr_c5_oe", 16'(ad_oe), 16'd1);
        check("wr_c5_out", 16'(ad_out), 16'h0F);
        check("wr_c5_rdv", 16'(rd_valid), 16'd0);
        tick;
        check("wr_c6_oe", 16'(ad_oe), 16'd0);
        check("wr_c6_rdv", 16'(rd_valid), 16'd0);

        // Back-to-back read 0x0010 then write 0x0020 <- 0xAA
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0010; ad_in = 8'h77;
        tick;
        req_we = 1'b1; req_addr = 14'h0020; req_wdata = 8'hAA;
        check("b2b_c1_out", 16'(ad_out), 16'h10);
        tick; tick; tick;
        check("b2b_c4_ready", 16'(req_ready), 16'd0);
        tick;
        check("b2b_c5_rdv", 16'(rd_valid), 16'd1);
        check("b2b_c5_rdd", 16'(rd_data), 16'h77);
        check("b2b_c5_ready", 16'(req_ready), 16'd1);
        tick;
        req_valid = 1'b0;
        check("b2b_c6_ale", 16'(ale), 16'd1);
        check("b2b_c6_out", 16'(ad_out), 16'h20);
        check("b2b_c6_rdv", 16'(rd_valid), 16'd0);
        tick; tick;
        check("b2b_c8_nwr", 16'(n_wr), 16'd0);
        check("b2b_c8_out", 16'(ad_out), 16'hAA);
        tick; tick;
        check("b2b_c10_rdv", 16'(rd_valid), 16'd0);
        check("b2b_c10_oe", 16'(ad_oe), 16'd1);
        tick;
        check("b2b_c11_oe", 16'(ad_oe), 16'd0);

        // Reset during cycle 3 of a read
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0555; ad_in = 8'h99;
        tick;
        req_valid = 1'b0;
        tick; tick;
        check("abort_c3_nrd", 16'(n_rd), 16'd0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_c4_nrd", 16'(n_rd), 16'd1);
        check("abort_c4_oe", 16'(ad_oe), 16'd0);
        check("abort_c4_pa", 16'(pa_hi), 16'h00);
        tick;
        check("abort_c5_rdv", 16'(rd_valid), 16'd0);
        check("abort_c5_ready", 16'(req_ready), 16'd1);
        check("abort_c5_ale", 16'(ale), 16'd0);
        req_valid = 1'b1; req_addr = 14'h1234; ad_in = 8'hC3;
        tick;
        req_valid = 1'b0;
        check("after_c1_out", 16'(ad_out), 16'h34);
        check("after_c1_pa", 16'(pa_hi), 16'h12);
        tick; tick; tick; tick;
        check("after_c5_rdv", 16'(rd_valid), 16'd1);
        check("after_c5_rdd", 16'(rd_data), 16'hC3);

        // Stretched timing instance: ALE_CYC=2, STB_CYC=3
        tick;
        req_valid2 = 1'b1; req_we = 1'b0; req_addr = 14'h0ABC; ad_in = 8'hEE;
        tick;
        req_valid2 = 1'b0;
        check("slow_c1_ale", 16'(ale2), 16'd1);
        check("slow_c1_out", 16'(ad_out2), 16'hBC);
        tick;
        check("slow_c2_ale", 16'(ale2), 16'd1);
        tick;
        check("slow_c3_ale", 16'(ale2), 16'd0);
        check("slow_c3_nrd", 16'(n_rd2), 16'd1);
        tick;
        ad_in = 8'h01;
        check("slow_c4_nrd", 16'(n_rd2), 16'd0);
        tick;
        ad_in = 8'h02;
        check("slow_c5_nrd", 16'(n_rd2), 16'd0);
        tick;
        ad_in = 8'h03;
        check("slow_c6_nrd", 16'(n_rd2), 16'd0);
        check("slow_c6_rdv", 16'(rd_valid2), 16'd0);
        tick;
        ad_in = 8'h04;
        check("slow_c7_rdv", 16'(rd_valid2), 16'd1);
        check("slow_c7_rdd", 16'(rd_data2), 16'h03);
        check("slow_c7_nrd", 16'(n_rd2), 16'd1);
        tick;
        check("slow_c8_rdv", 16'(rd_valid2), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
